// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter and sequencer in front of a single-port word RAM.
//
// The IFU (read only) and the LSU (read/write) compete for the RAM. One request is
// accepted at a time. The accepted access is held on the RAM bus for RAM_LATENCY cycles.
// The read data is then captured and returned on the owner's response handshake.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   ifu_req_*             IFU read request (valid/ready, byte address)
//   ifu_resp_*            IFU response (valid/ready, read data)
//   lsu_req_*             LSU request (valid/ready, byte address, write enable, write data)
//   lsu_resp_*            LSU response (valid/ready, read data; writes return pre-write word)
//   ram_*                 RAM strobe, word-aligned address, write enable, write/read data
//   owner                 current or last owner: 0 = IFU, 1 = LSU
//
// Configuration macro RAM_ARB_RR_EN selects round-robin arbitration when defined.
// When it is undefined, arbitration is fixed priority and the LSU wins.

module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
    output logic                  ram_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wen,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  owner
);

    if ((RAM_LATENCY == 0) || (RAM_LATENCY > 15)) begin : g_latency_check
        $error("ram_arbiter: RAM_LATENCY must be in the range 1..15");
    end

    localparam logic [3:0] LastCnt = 4'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  owner_q;
    logic                  ram_valid_q;
    logic                  ram_wen_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic                  ifu_resp_valid_q;
    logic                  lsu_resp_valid_q;
    logic [DATA_WIDTH-1:0] ifu_rdata_q;
    logic [DATA_WIDTH-1:0] lsu_rdata_q;

    logic idle;
    logic ifu_acc;
    logic lsu_acc;
    logic owner_resp_ready;

    assign idle = (state_q == StIdle);

`ifdef RAM_ARB_RR_EN
    logic last_grant_q;

    // On a tie the master not granted last wins; a lone requester always gets ready.
    assign lsu_req_ready = idle & ~(ifu_req_valid & last_grant_q);
    assign ifu_req_ready = idle & ~(lsu_req_valid & ~last_grant_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (ifu_acc || lsu_acc) begin
            last_grant_q <= lsu_acc;
        end
    end
`else
    assign lsu_req_ready = idle;
    assign ifu_req_ready = idle & ~lsu_req_valid;
`endif

    assign lsu_acc = lsu_req_valid & lsu_req_ready;
    assign ifu_acc = ifu_req_valid & ifu_req_ready;

    assign owner_resp_ready = owner_q ? lsu_resp_ready : ifu_resp_ready;

    // Byte-offset bits never reach the word-addressed RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ifu_req_addr[1:0], lsu_req_addr[1:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            owner_q          <= 1'b0;
            ram_valid_q      <= 1'b0;
            ram_wen_q        <= 1'b0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (lsu_acc) begin
                        state_q     <= StWait;
                        cnt_q       <= '0;
                        owner_q     <= 1'b1;
                        ram_valid_q <= 1'b1;
                        ram_addr_q  <= {lsu_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        ram_wen_q   <= lsu_req_wen;
                        ram_wdata_q <= lsu_req_wdata;
                    end else if (ifu_acc) begin
                        state_q     <= StWait;
                        cnt_q       <= '0;
                        owner_q     <= 1'b0;
                        ram_valid_q <= 1'b1;
                        ram_addr_q  <= {ifu_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        ram_wen_q   <= 1'b0;
                        ram_wdata_q <= '0;
                    end
                end
                StWait: begin
                    if (cnt_q == LastCnt) begin
                        // Last RAM cycle: capture into the owner's response register only.
                        state_q     <= StResp;
                        ram_valid_q <= 1'b0;
                        ram_wen_q   <= 1'b0;
                        if (owner_q) begin
                            lsu_rdata_q      <= ram_rdata;
                            lsu_resp_valid_q <= 1'b1;
                        end else begin
                            ifu_rdata_q      <= ram_rdata;
                            ifu_resp_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StResp: begin
                    if (owner_resp_ready) begin
                        state_q          <= StIdle;
                        ifu_resp_valid_q <= 1'b0;
                        lsu_resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign owner          = owner_q;
    assign ram_valid      = ram_valid_q;
    assign ram_wen        = ram_wen_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_resp_rdata = ifu_rdata_q;
    assign lsu_resp_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
// Instance a uses RAM_LATENCY = 1 with a small writable RAM model.
// Instance b uses RAM_LATENCY = 3 with a read-only RAM that returns ~address.

module tb_ram_arbiter;

    logic clock;
    logic reset_n;

    // Instance a (L = 1)
    logic        a_ifu_req_valid, a_ifu_req_ready, a_ifu_resp_valid, a_ifu_resp_ready;
    logic [31:0] a_ifu_req_addr, a_ifu_resp_rdata;
    logic        a_lsu_req_valid, a_lsu_req_ready, a_lsu_req_wen, a_lsu_resp_valid;
    logic        a_lsu_resp_ready;
    logic [31:0] a_lsu_req_addr, a_lsu_req_wdata, a_lsu_resp_rdata;
    logic        a_ram_valid, a_ram_wen, a_owner;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    // Instance b (L = 3)
    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready;
    logic [31:0] b_ifu_req_addr, b_ifu_resp_rdata;
    logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_req_wen, b_lsu_resp_valid;
    logic        b_lsu_resp_ready;
    logic [31:0] b_lsu_req_addr, b_lsu_req_wdata, b_lsu_resp_rdata;
    logic        b_ram_valid, b_ram_wen, b_owner;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    int checks = 0;
    int fails  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(1)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_valid(a_ifu_req_valid), .ifu_req_ready(a_ifu_req_ready),
        .ifu_req_addr(a_ifu_req_addr), .ifu_resp_valid(a_ifu_resp_valid),
        .ifu_resp_ready(a_ifu_resp_ready), .ifu_resp_rdata(a_ifu_resp_rdata),
        .lsu_req_valid(a_lsu_req_valid), .lsu_req_ready(a_lsu_req_ready),
        .lsu_req_addr(a_lsu_req_addr), .lsu_req_wen(a_lsu_req_wen),
        .lsu_req_wdata(a_lsu_req_wdata), .lsu_resp_valid(a_lsu_resp_valid),
        .lsu_resp_ready(a_lsu_resp_ready), .lsu_resp_rdata(a_lsu_resp_rdata),
        .ram_valid(a_ram_valid), .ram_addr(a_ram_addr), .ram_wen(a_ram_wen),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .owner(a_owner)
    );

    ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(3)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready),
        .ifu_req_addr(b_ifu_req_addr), .ifu_resp_valid(b_ifu_resp_valid),
        .ifu_resp_ready(b_ifu_resp_ready), .ifu_resp_rdata(b_ifu_resp_rdata),
        .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready),
        .lsu_req_addr(b_lsu_req_addr), .lsu_req_wen(b_lsu_req_wen),
        .lsu_req_wdata(b_lsu_req_wdata), .lsu_resp_valid(b_lsu_resp_valid),
        .lsu_resp_ready(b_lsu_resp_ready), .lsu_resp_rdata(b_lsu_resp_rdata),
        .ram_valid(b_ram_valid), .ram_addr(b_ram_addr), .ram_wen(b_ram_wen),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .owner(b_owner)
    );

    // RAM model a: 16 words; unwritten words read as a fixed pattern.
    function automatic logic [31:0] init_word(input int idx);
        return 32'h1000_0000 + 32'(idx) * 32'h11;
    endfunction

    logic [31:0] mem_a [16];
    logic [15:0] wr_a;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_a <= '0;
        end else if (a_ram_valid && a_ram_wen) begin
            wr_a[a_ram_addr[5:2]]  <= 1'b1;
            mem_a[a_ram_addr[5:2]] <= a_ram_wdata;
        end
    end

    assign a_ram_rdata = wr_a[a_ram_addr[5:2]] ? mem_a[a_ram_addr[5:2]]
                                               : init_word(int'(a_ram_addr[5:2]));
    assign b_ram_rdata = ~b_ram_addr;

    task automatic test_reset();
        reset_n = 1'b1;
        a_ifu_req_valid = 0; a_ifu_req_addr = '0; a_ifu_resp_ready = 1;
        a_lsu_req_valid = 0; a_lsu_req_addr = '0; a_lsu_req_wen = 0;
        a_lsu_req_wdata = '0; a_lsu_resp_ready = 1;
        b_ifu_req_valid = 0; b_ifu_req_addr = '0; b_ifu_resp_ready = 1;
        b_lsu_req_valid = 0; b_lsu_req_addr = '0; b_lsu_req_wen = 0;
        b_lsu_req_wdata = '0; b_lsu_resp_ready = 1;
        #1 reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if ({a_ram_valid, a_ram_wen, a_ifu_resp_valid, a_lsu_resp_valid, a_owner} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {a_ram_valid, a_ram_wen, a_ifu_resp_valid, a_lsu_resp_valid, a_owner});
        end
        checks++;
        if ({a_ram_addr, a_ram_wdata, a_ifu_resp_rdata, a_lsu_resp_rdata} !== 128'b0) begin
            fails++;
            $display("FAIL reset_data: addr %h wdata %h irdata %h lrdata %h want all 0",
                     a_ram_addr, a_ram_wdata, a_ifu_resp_rdata, a_lsu_resp_rdata);
        end
        checks++;
        if ({a_ifu_req_ready, a_lsu_req_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready: got %b want 11", {a_ifu_req_ready, a_lsu_req_ready});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_ifu_read();
        @(negedge clock);
        a_ifu_req_valid = 1; a_ifu_req_addr = 32'h8000_0006;
        #1;
        checks++;
        if (a_ifu_req_ready !== 1'b1) begin
            fails++; $display("FAIL ifu_ready: got %b want 1", a_ifu_req_ready);
        end
        @(negedge clock);
        a_ifu_req_valid = 0;
        checks++;
        if ({a_ram_valid, a_ram_wen, a_ram_addr, a_ifu_resp_valid} !== {2'b10, 32'h8000_0004, 1'b0})
        begin
            fails++;
            $display("FAIL ifu_wait: valid %b wen %b addr %h rv %b want 1 0 80000004 0",
                     a_ram_valid, a_ram_wen, a_ram_addr, a_ifu_resp_valid);
        end
        @(negedge clock);
        checks++;
        if ({a_ram_valid, a_ifu_resp_valid, a_lsu_resp_valid, a_owner} !== 4'b0100 ||
            a_ifu_resp_rdata !== init_word(1)) begin
            fails++;
            $display("FAIL ifu_resp: rv %b lv %b ramv %b owner %b rdata %h want 1 0 0 0 %h",
                     a_ifu_resp_valid, a_lsu_resp_valid, a_ram_valid, a_owner,
                     a_ifu_resp_rdata, init_word(1));
        end
        @(negedge clock);
        checks++;
        if ({a_ifu_resp_valid, a_ifu_req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL ifu_idle: rv %b ready %b want 0 1", a_ifu_resp_valid, a_ifu_req_ready);
        end
    endtask

    task automatic test_lsu_write_read();
        a_lsu_req_valid = 1; a_lsu_req_addr = 32'h8000_0010;
        a_lsu_req_wen = 1; a_lsu_req_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        a_lsu_req_valid = 0; a_lsu_req_wen = 0;
        checks++;
        if ({a_ram_valid, a_ram_wen, a_ram_addr, a_ram_wdata} !==
            {2'b11, 32'h8000_0010, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL wr_wait: valid %b wen %b addr %h wdata %h want 1 1 80000010 deadbeef",
                     a_ram_valid, a_ram_wen, a_ram_addr, a_ram_wdata);
        end
        @(negedge clock);
        checks++;
        if ({a_lsu_resp_valid, a_ifu_resp_valid, a_ram_wen, a_owner} !== 4'b1001 ||
            a_lsu_resp_rdata !== init_word(4) || a_ifu_resp_rdata !== init_word(1)) begin
            fails++;
            $display("FAIL wr_resp: lv %b iv %b wen %b own %b lrd %h ird %h want 1 0 0 1 %h %h",
                     a_lsu_resp_valid, a_ifu_resp_valid, a_ram_wen, a_owner, a_lsu_resp_rdata,
                     a_ifu_resp_rdata, init_word(4), init_word(1));
        end
        @(negedge clock);
        a_lsu_req_valid = 1; a_lsu_req_addr = 32'h8000_0011; a_lsu_req_wen = 0;
        @(negedge clock);
        a_lsu_req_valid = 0;
        checks++;
        if ({a_ram_valid, a_ram_wen, a_ram_addr} !== {2'b10, 32'h8000_0010}) begin
            fails++;
            $display("FAIL rd_wait: valid %b wen %b addr %h want 1 0 80000010",
                     a_ram_valid, a_ram_wen, a_ram_addr);
        end
        @(negedge clock);
        checks++;
        if (a_lsu_resp_valid !== 1'b1 || a_lsu_resp_rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL rd_resp: lv %b rdata %h want 1 deadbeef",
                     a_lsu_resp_valid, a_lsu_resp_rdata);
        end
        @(negedge clock);
    endtask

`ifndef RAM_ARB_RR_EN
    task automatic test_fixed_priority();
        a_ifu_req_valid = 1; a_ifu_req_addr = 32'h8000_0008;
        a_lsu_req_valid = 1; a_lsu_req_addr = 32'h8000_000C; a_lsu_req_wen = 0;
        #1;
        checks++;
        if ({a_ifu_req_ready, a_lsu_req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL prio_ready: ifu %b lsu %b want 0 1", a_ifu_req_ready, a_lsu_req_ready);
        end
        @(negedge clock);
        a_lsu_req_valid = 0;
        checks++;
        if ({a_owner, a_ram_addr, a_ifu_req_ready} !== {1'b1, 32'h8000_000C, 1'b0}) begin
            fails++;
            $display("FAIL prio_first: owner %b addr %h ifu_ready %b want 1 8000000c 0",
                     a_owner, a_ram_addr, a_ifu_req_ready);
        end
        @(negedge clock);
        checks++;
        if (a_lsu_resp_valid !== 1'b1 || a_lsu_resp_rdata !== init_word(3) ||
            a_ifu_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_lresp: lv %b rdata %h ifu_ready %b want 1 %h 0",
                     a_lsu_resp_valid, a_lsu_resp_rdata, a_ifu_req_ready, init_word(3));
        end
        @(negedge clock);
        checks++;
        if (a_ifu_req_ready !== 1'b1) begin
            fails++; $display("FAIL prio_ifu_ready: got %b want 1", a_ifu_req_ready);
        end
        @(negedge clock);
        a_ifu_req_valid = 0;
        checks++;
        if ({a_owner, a_ram_valid, a_ram_addr} !== {2'b01, 32'h8000_0008}) begin
            fails++;
            $display("FAIL prio_second: owner %b valid %b addr %h want 0 1 80000008",
                     a_owner, a_ram_valid, a_ram_addr);
        end
        @(negedge clock);
        checks++;
        if (a_ifu_resp_valid !== 1'b1 || a_ifu_resp_rdata !== init_word(2)) begin
            fails++;
            $display("FAIL prio_iresp: iv %b rdata %h want 1 %h",
                     a_ifu_resp_valid, a_ifu_resp_rdata, init_word(2));
        end
        @(negedge clock);
    endtask
`else
    task automatic test_round_robin();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        a_ifu_req_valid = 1; a_ifu_req_addr = 32'h8000_0004;
        a_lsu_req_valid = 1; a_lsu_req_addr = 32'h8000_0010; a_lsu_req_wen = 0;
        #1;
        checks++;
        if ({a_ifu_req_ready, a_lsu_req_ready} !== 2'b10) begin
            fails++;
            $display("FAIL rr_ready: ifu %b lsu %b want 1 0", a_ifu_req_ready, a_lsu_req_ready);
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            checks++;
            if ({a_ram_valid, a_owner} !== {1'b1, t[0]}) begin
                fails++;
                $display("FAIL rr_grant%0d: valid %b owner %b want 1 %b",
                         t, a_ram_valid, a_owner, t[0]);
            end
            repeat (2) @(negedge clock);
        end
        a_ifu_req_valid = 0; a_lsu_req_valid = 0;
        repeat (3) @(negedge clock);
    endtask
`endif

    task automatic test_backpressure();
        int hi = 0;
        b_lsu_req_valid = 1; b_lsu_req_addr = 32'h8000_0020; b_lsu_req_wen = 0;
        b_lsu_resp_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) b_lsu_req_valid = 0;
            if (b_ram_valid) hi++;
            if (k >= 4) begin
                checks++;
                if ({b_lsu_resp_valid, b_lsu_req_ready} !== 2'b10 ||
                    b_lsu_resp_rdata !== ~32'h8000_0020) begin
                    fails++;
                    $display("FAIL stall%0d: rv %b req_ready %b rdata %h want 1 0 %h",
                             k, b_lsu_resp_valid, b_lsu_req_ready, b_lsu_resp_rdata,
                             ~32'h8000_0020);
                end
            end
            if (k == 4) begin
                b_lsu_req_valid = 1; b_lsu_req_addr = 32'h8000_0030;
            end
        end
        checks++;
        if (hi !== 3) begin
            fails++; $display("FAIL lat3_cycles: ram_valid high %0d cycles want 3", hi);
        end
        b_lsu_resp_ready = 1; b_lsu_req_valid = 0;
        @(negedge clock);
        checks++;
        if ({b_lsu_resp_valid, b_lsu_req_ready, b_ram_valid} !== 3'b010) begin
            fails++;
            $display("FAIL stall_release: rv %b ready %b ramv %b want 0 1 0",
                     b_lsu_resp_valid, b_lsu_req_ready, b_ram_valid);
        end
    endtask

    task automatic test_async_reset();
        int hi = 0;
        b_ifu_req_valid = 1; b_ifu_req_addr = 32'h8000_0040;
        @(negedge clock);
        b_ifu_req_valid = 0;
        checks++;
        if (b_ram_valid !== 1'b1) begin
            fails++; $display("FAIL arst_wait: ram_valid %b want 1", b_ram_valid);
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({b_ram_valid, b_ram_wen, b_ifu_resp_valid, b_lsu_resp_valid} !== 4'b0 ||
            b_ram_addr !== 32'h0) begin
            fails++;
            $display("FAIL arst_now: ramv %b wen %b iv %b lv %b addr %h want 0 0 0 0 0",
                     b_ram_valid, b_ram_wen, b_ifu_resp_valid, b_lsu_resp_valid, b_ram_addr);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if ({b_ifu_resp_valid, b_ram_valid} !== 2'b00) begin
                fails++;
                $display("FAIL arst_noresp%0d: iv %b ramv %b want 0 0",
                         k, b_ifu_resp_valid, b_ram_valid);
            end
        end
        b_ifu_req_valid = 1; b_ifu_req_addr = 32'h8000_0044;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 1) b_ifu_req_valid = 0;
            if (b_ram_valid) hi++;
        end
        checks++;
        if (hi !== 3 || b_ifu_resp_valid !== 1'b1 || b_ifu_resp_rdata !== ~32'h8000_0044) begin
            fails++;
            $display("FAIL arst_after: ramv cycles %0d iv %b rdata %h want 3 1 %h",
                     hi, b_ifu_resp_valid, b_ifu_resp_rdata, ~32'h8000_0044);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_write_read();
`ifndef RAM_ARB_RR_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
